mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port memory with fixed read latency.
// One transaction in flight at a time; ties alternate between requesters.
module mem_port_arbiter #(
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic        req0_we,
   input  logic        req1_we,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req0_wdata,
   input  logic [31:0] req1_wdata,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   output logic [31:0] rsp0_rdata,
   output logic [31:0] rsp1_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [1:0] CNT_LOAD = 2'((LATENCY > 1) ? (LATENCY - 2) : 0);

   state_t     r_state;
   state_t     w_nextState;
   logic [1:0] r_cnt;
   logic [1:0] w_nextCnt;
   logic       r_lastGrant;
   logic       r_gntId;
   logic       r_isRead;
   logic       r_postRst;
   logic       w_canAccept;
   logic       w_grant0;
   logic       w_grant1;
   logic       w_accept;
   logic       w_respOn;

   // r_postRst keeps the cycle right after reset fully quiet.
   always_comb begin
      w_canAccept = rst && !r_postRst && (r_state != WAIT);
      w_grant0    = w_canAccept && req0_valid && (!req1_valid || r_lastGrant);
      w_grant1    = w_canAccept && req1_valid && (!req0_valid || !r_lastGrant);
      w_accept    = w_grant0 || w_grant1;
   end

   always_comb begin
      req0_ready = w_grant0;
      req1_ready = w_grant1;
      mem_en     = w_accept;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (w_grant0) begin
         mem_we    = req0_we;
         mem_addr  = req0_addr;
         mem_wdata = req0_wdata;
      end else if (w_grant1) begin
         mem_we    = req1_we;
         mem_addr  = req1_addr;
         mem_wdata = req1_wdata;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      case (r_state)
         IDLE, RESP: begin
            if (w_accept) begin
               if (LATENCY == 1) begin
                  w_nextState = RESP;
               end else begin
                  w_nextState = WAIT;
                  w_nextCnt   = CNT_LOAD;
               end
            end else begin
               w_nextState = IDLE;
            end
         end
         WAIT: begin
            if (r_cnt == 2'd0) begin
               w_nextState = RESP;
            end else begin
               w_nextCnt = r_cnt - 2'd1;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cnt       <= 2'd0;
         r_lastGrant <= 1'b1;
         r_gntId     <= 1'b0;
         r_isRead    <= 1'b0;
         r_postRst   <= 1'b1;
      end else begin
         r_state   <= w_nextState;
         r_cnt     <= w_nextCnt;
         r_postRst <= 1'b0;
         if (w_accept) begin
            r_lastGrant <= w_grant1;
            r_gntId     <= w_grant1;
            r_isRead    <= w_grant1 ? !req1_we : !req0_we;
         end
      end
   end

   // Response goes only to the latched grantee; writes complete with zero data.
   always_comb begin
      w_respOn   = rst && (r_state == RESP);
      rsp0_valid = w_respOn && !r_gntId;
      rsp1_valid = w_respOn && r_gntId;
      rsp0_rdata = (rsp0_valid && r_isRead) ? mem_rdata : '0;
      rsp1_rdata = (rsp1_valid && r_isRead) ? mem_rdata : '0;
      busy       = rst && (r_state != IDLE);
   end

endmodule
